// File: rtl/aes_ser_tx.sv
// -----------------------------------------------------------------------------
// aes_ser_tx
//
// Parallel-to-serial transmitter feeding the AES chip's serial input. A block
// of WIDTH bits is taken from the controller over a valid/ready handshake and
// shifted out MSB-first, one bit per period of the divided clock. The divided
// clock arrives already registered in the clk_in domain. Its rising edges are
// detected and used as bit strobes, so all logic runs on clk_in.
//
// Ports
//   clk_in    system clock, rising edge
//   rst_n     asynchronous active-low reset
//   div_clk   divided clock (clk_in domain) used as the bit strobe source
//   in_data   block to transmit, sampled only in the acceptance cycle
//   in_valid  in_data is valid
//   in_ready  registered; high only while idle and able to accept a block
//   ser_dat   serial data, MSB first
//   ser_en    high while ser_dat carries a valid bit
//   done      one-cycle pulse when a block has finished transmitting
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a block; in_ready high (one cycle after a block ends)
// ARM   | block latched, waiting for the first div_clk rise to align bit 0
// SHIFT | one bit presented per div_clk rise; the extra rise closes the block
// -----------------------------------------------------------------------------
module aes_ser_tx #(
    parameter int WIDTH = 128
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             div_clk,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_dat,
    output logic             ser_en,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t           state;
    logic             div_prev;
    logic             rise;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] bit_cnt;

    assign rise = div_clk & ~div_prev;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            div_prev <= 1'b0;
        end else begin
            div_prev <= div_clk;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            in_ready <= 1'b1;
            ser_dat  <= 1'b0;
            ser_en   <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // Re-raising in_ready here (not on the closing rise) keeps
                    // it low during the done cycle.
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        shreg    <= in_data;
                        bit_cnt  <= '0;
                        in_ready <= 1'b0;
                        state    <= ARM;
                    end
                end
                ARM: begin
                    // A rise coincident with acceptance was seen in IDLE and is
                    // therefore never counted here.
                    if (rise) begin
                        ser_dat <= shreg[WIDTH-1];
                        shreg   <= {shreg[WIDTH-2:0], 1'b0};
                        ser_en  <= 1'b1;
                        bit_cnt <= CNT_ONE;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (rise) begin
                        if (bit_cnt == CNT_LAST) begin
                            // Last bit has been held a full period; close out.
                            ser_en  <= 1'b0;
                            ser_dat <= 1'b0;
                            done    <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            ser_dat <= shreg[WIDTH-1];
                            shreg   <= {shreg[WIDTH-2:0], 1'b0};
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_ser_tx.sv
// -----------------------------------------------------------------------------
// tb_aes_ser_tx
//
// Directed bench for aes_ser_tx with WIDTH = 8. div_clk comes from a divide-
// by-4 counter clocked by clk_in, giving one rise every 4 cycles. Outputs are
// sampled on the falling edge of clk_in.
// -----------------------------------------------------------------------------
module tb_aes_ser_tx;

    localparam int W = 8;

    logic         clk_in = 1'b0;
    logic         rst_n  = 1'b1;
    logic         div_clk;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         ser_dat;
    logic         ser_en;
    logic         done;

    aes_ser_tx #(.WIDTH(W)) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .div_clk  (div_clk),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ser_dat  (ser_dat),
        .ser_en   (ser_en),
        .done     (done)
    );

    always #5 clk_in = ~clk_in;

    // Divide-by-4 clock source, registered on clk_in.
    logic [1:0] dcnt;
    logic       div_d;
    logic       rise_tb;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            dcnt    <= 2'd0;
            div_clk <= 1'b0;
            div_d   <= 1'b0;
        end else begin
            dcnt  <= dcnt + 2'd1;
            div_d <= div_clk;
            if (dcnt[0]) div_clk <= ~div_clk;
        end
    end

    assign rise_tb = div_clk & ~div_d;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Results of the most recent collect.
    logic [7:0] got;
    int         en_cyc;
    int         lead;
    int         done_n;
    int         unstable;
    logic       rdy_at_done;
    logic       en_at_done;
    logic       dat_at_done;
    int         rdy_wait;

    // Waits for in_ready, optionally aligns to a rise cycle, and offers one
    // block for exactly one cycle. Returns at the first negedge after acceptance.
    task automatic start_block(input logic [7:0] d, input bit align);
        bit ok;
        ok = 0;
        rdy_wait = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_in);
            rdy_wait++;
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check_val("ready_timeout", 32'd0, 32'd1);
        if (align) begin
            for (int c = 0; c < 8 && !rise_tb; c++) @(negedge clk_in);
        end
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk_in);
        in_valid = 1'b0;
        in_data  = 8'h5A;
    endtask

    // Samples the serial output each cycle until done (bounded). Optionally
    // pulses in_valid with 0x3C partway through the transfer.
    task automatic collect(input bit inj);
        logic smp [0:31];
        bit   seen_en;
        bit   fin;
        for (int i = 0; i < 32; i++) smp[i] = 1'b0;
        seen_en = 0; fin = 0;
        en_cyc = 0; lead = 0; done_n = 0; unstable = 0;
        rdy_at_done = 1'bx; en_at_done = 1'bx; dat_at_done = 1'bx;
        for (int c = 0; c < 60 && !fin; c++) begin
            if (c > 0) @(negedge clk_in);
            if (inj) begin
                if (en_cyc == 10) begin
                    in_valid = 1'b1;
                    in_data  = 8'h3C;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (ser_en === 1'b1) begin
                if (en_cyc < 32) smp[en_cyc] = ser_dat;
                en_cyc++;
                seen_en = 1;
            end else if (!seen_en) begin
                lead++;
            end
            if (done === 1'b1) begin
                done_n++;
                rdy_at_done = in_ready;
                en_at_done  = ser_en;
                dat_at_done = ser_dat;
                fin = 1;
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            got[7-i] = smp[4*i];
            for (int k = 1; k < 4; k++)
                if (smp[4*i+k] !== smp[4*i]) unstable++;
        end
    endtask

    task automatic check_block(input string pfx, input logic [7:0] exp);
        check_val({pfx, "_bits"},     32'(got),         32'(exp));
        check_val({pfx, "_en_cyc"},   32'(en_cyc),      32'd32);
        check_val({pfx, "_unstable"}, 32'(unstable),    32'd0);
        check_val({pfx, "_done_n"},   32'(done_n),      32'd1);
        check_val({pfx, "_en_done"},  32'(en_at_done),  32'd0);
        check_val({pfx, "_dat_done"}, 32'(dat_at_done), 32'd0);
        check_val({pfx, "_rdy_done"}, 32'(rdy_at_done), 32'd0);
    endtask

    int   n_en;
    int   n_dn;
    logic pre_en;
    logic pre_dat;

    initial begin
        // ---- reset values ----
        #1 rst_n = 1'b0;
        #1;
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_ser_en",   32'(ser_en),   32'd0);
        check_val("rst_ser_dat",  32'(ser_dat),  32'd0);
        check_val("rst_done",     32'(done),     32'd0);
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_in);

        // ---- single transfer 0xA5 ----
        start_block(8'hA5, 1'b0);
        collect(1'b0);
        check_block("single", 8'hA5);
        @(negedge clk_in);
        check_val("single_rdy_after",  32'(in_ready), 32'd1);
        check_val("single_done_after", 32'(done),     32'd0);
        repeat (3) @(negedge clk_in);

        // ---- back-to-back 0xFF then 0x00 ----
        start_block(8'hFF, 1'b0);
        collect(1'b0);
        check_block("b2b_ff", 8'hFF);
        start_block(8'h00, 1'b0);
        check_val("b2b_rdy_wait", 32'(rdy_wait), 32'd1);
        collect(1'b0);
        // done cycle + ready cycle + 2 sampled ARM cycles = one div_clk period
        check_val("b2b_lead", 32'(lead), 32'd2);
        check_block("b2b_00", 8'h00);

        // ---- busy ignore: 0x3C offered during 0x81 ----
        repeat (2) @(negedge clk_in);
        start_block(8'h81, 1'b0);
        collect(1'b1);
        check_block("busy", 8'h81);
        n_en = 0; n_dn = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_in);
            if (ser_en === 1'b1) n_en++;
            if (done === 1'b1) n_dn++;
        end
        check_val("busy_extra_en",   32'(n_en), 32'd0);
        check_val("busy_extra_done", 32'(n_dn), 32'd0);

        // ---- edge coincidence: accept 0xC3 in a rise cycle ----
        start_block(8'hC3, 1'b1);
        collect(1'b0);
        check_val("coinc_lead", 32'(lead), 32'd4);
        check_block("coinc", 8'hC3);

        // ---- reset mid-transfer of 0xF0, then 0x0F ----
        repeat (2) @(negedge clk_in);
        start_block(8'hF0, 1'b0);
        n_en = 0; n_dn = 0;
        for (int c = 0; c < 40 && n_en < 12; c++) begin
            if (ser_en === 1'b1) n_en++;
            if (done === 1'b1) n_dn++;
            if (n_en < 12) @(negedge clk_in);
        end
        check_val("mid_en_bits", 32'(n_en), 32'd12);
        pre_en  = ser_en;
        pre_dat = ser_dat;
        check_val("mid_pre_en",  32'(pre_en),  32'd1);
        check_val("mid_pre_dat", 32'(pre_dat), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_val("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check_val("mid_rst_ser_en",   32'(ser_en),   32'd0);
        check_val("mid_rst_ser_dat",  32'(ser_dat),  32'd0);
        check_val("mid_rst_done",     32'(done),     32'd0);
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
        check_val("mid_no_done", 32'(n_dn), 32'd0);
        start_block(8'h0F, 1'b0);
        collect(1'b0);
        check_block("after_rst", 8'h0F);

        repeat (4) @(negedge clk_in);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
